// File: rtl/coarse_delay_start.sv
// coarse_delay_start
//   Converts an asynchronous external trigger into one clean start pulse on
//   m_clk. The pulse is delayed by a programmable number of whole cycles and
//   has a programmable width. start_pulse feeds the fine (tap) delay stage
//   directly, so the coarse and fine delays add.
//
// Ports
//   m_clk, reset    clock / asynchronous active-high reset
//   trig_in         asynchronous trigger, acted on at its rising edge
//   arm, abort      one-cycle control requests (abort wins over everything)
//   continuous      rearm automatically after each pulse
//   cfg_load        latch coarse_delay / pulse_width (only in IDLE or ARMED)
//   coarse_delay    delay D in cycles
//   pulse_width     width W in cycles, 0 behaves as 1
//   start_pulse     registered start pulse
//   armed, busy     registered state flags
//   missed_trig     one-cycle flag for a trigger edge that arrived while busy
module coarse_delay_start #(
  parameter int CNT_W       = 16,
  parameter int WID_W       = 8,
  parameter int SYNC_STAGES = 2   // 2 or 3
) (
  input  logic             m_clk,
  input  logic             reset,
  input  logic             trig_in,
  input  logic             arm,
  input  logic             abort,
  input  logic             continuous,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] coarse_delay,
  input  logic [WID_W-1:0] pulse_width,
  output logic             start_pulse,
  output logic             armed,
  output logic             busy,
  output logic             missed_trig
);

  typedef enum logic [1:0] {IDLE, ARMED, DELAY, PULSE} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] delay;
    logic [WID_W-1:0] width;   // never 0
  } cfg_t;

  state_t                 state_q, state_d;
  cfg_t                   cfg_q;
  logic [CNT_W-1:0]       dcnt_q, dcnt_d;
  logic [WID_W-1:0]       wcnt_q, wcnt_d;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   hist_q;
  logic                   trig_edge;
  logic                   in_busy;

  // Synchroniser plus history flop; runs in every state so that a level
  // already high at arm time never looks like a fresh edge.
  always_ff @(posedge m_clk or posedge reset) begin
    if (reset) begin
      sync_pipe <= '0;
      hist_q    <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], trig_in};
      hist_q    <= sync_pipe[SYNC_STAGES-1];
    end
  end

  assign trig_edge = sync_pipe[SYNC_STAGES-1] & ~hist_q;
  assign in_busy   = (state_q == DELAY) || (state_q == PULSE);

  // Config is frozen while a shot is running.
  always_ff @(posedge m_clk or posedge reset) begin
    if (reset) begin
      cfg_q.delay <= '0;
      cfg_q.width <= WID_W'(1);
    end else if (cfg_load && !in_busy) begin
      cfg_q.delay <= coarse_delay;
      cfg_q.width <= (pulse_width == '0) ? WID_W'(1) : pulse_width;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE:  if (arm) state_d = ARMED;
      ARMED: begin
        if (trig_edge) begin
          if (cfg_q.delay == '0) begin
            state_d = PULSE;
            wcnt_d  = cfg_q.width - WID_W'(1);
          end else begin
            state_d = DELAY;
            dcnt_d  = cfg_q.delay - CNT_W'(1);
          end
        end
      end
      DELAY: begin
        if (dcnt_q == '0) begin
          state_d = PULSE;
          wcnt_d  = cfg_q.width - WID_W'(1);
        end else begin
          dcnt_d = dcnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (wcnt_q == '0) state_d = continuous ? ARMED : IDLE;
        else              wcnt_d  = wcnt_q - WID_W'(1);
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Outputs are flops loaded from the next state so they are glitch-free
  // toward the fine-delay stage.
  always_ff @(posedge m_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      wcnt_q      <= '0;
      start_pulse <= 1'b0;
      armed       <= 1'b0;
      busy        <= 1'b0;
      missed_trig <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      wcnt_q      <= wcnt_d;
      start_pulse <= (state_d == PULSE);
      armed       <= (state_d == ARMED);
      busy        <= (state_d == DELAY) || (state_d == PULSE);
      // Includes the last PULSE cycle: that edge is dropped even in continuous mode.
      missed_trig <= trig_edge & in_busy;
    end
  end

endmodule

// File: tb/tb_coarse_delay_start.sv
// Bench for coarse_delay_start: directed scenarios and randomized trigger
// traces compared cycle by cycle against an event-level model of the shot
// timing (edge cycle -> busy/pulse windows -> next ready cycle).
module tb_coarse_delay_start;
  localparam int CNT_W = 16;
  localparam int WID_W = 8;
  localparam int SS    = 2;
  localparam int N     = 200;

  logic             m_clk = 1'b0;
  logic             reset = 1'b1;
  logic             trig_in = 1'b0, arm = 1'b0, abort = 1'b0;
  logic             continuous = 1'b0, cfg_load = 1'b0;
  logic [CNT_W-1:0] coarse_delay = '0;
  logic [WID_W-1:0] pulse_width = '0;
  logic             start_pulse, armed, busy, missed_trig;

  int checks = 0;
  int errors = 0;

  logic pat     [N];
  logic o_pulse [N], o_busy [N], o_miss [N], o_armed [N];
  logic e_pulse [N], e_busy [N], e_miss [N], e_armed [N];

  always #5 m_clk = ~m_clk;

  coarse_delay_start #(.CNT_W(CNT_W), .WID_W(WID_W), .SYNC_STAGES(SS)) dut (
    .m_clk(m_clk), .reset(reset), .trig_in(trig_in), .arm(arm), .abort(abort),
    .continuous(continuous), .cfg_load(cfg_load), .coarse_delay(coarse_delay),
    .pulse_width(pulse_width), .start_pulse(start_pulse), .armed(armed),
    .busy(busy), .missed_trig(missed_trig)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge m_clk);
    #1;
  endtask

  // Return to IDLE, settle trig_in at 'pre', load config, arm.
  task automatic prep(int d, int w, bit cont, bit pre);
    abort = 1'b1; step(); abort = 1'b0;
    continuous = cont;
    trig_in = pre;
    repeat (4) step();
    coarse_delay = CNT_W'(d);
    pulse_width  = WID_W'(w);
    cfg_load = 1'b1; step(); cfg_load = 1'b0;
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  // pat[i] is sampled at edge i; outputs recorded just after edge i.
  task automatic drive_trace(int len);
    for (int i = 0; i < len; i++) begin
      trig_in = pat[i];
      step();
      o_pulse[i] = start_pulse;
      o_busy[i]  = busy;
      o_miss[i]  = missed_trig;
      o_armed[i] = armed;
    end
  endtask

  // Shot-level model: an edge seen in cycle j (while ready) makes cycles
  // j+1..j+D+W busy with the last W of them pulsing; the block is ready again
  // at j+D+W+1 in continuous mode, otherwise never. Edges landing in a busy
  // window raise missed_trig in the following cycle.
  function automatic void model_trace(int len, int d, int w, bit cont, bit pre);
    int weff, ready, last_busy;
    weff = (w == 0) ? 1 : w;
    ready = 0;
    last_busy = -1;
    for (int c = 0; c < len; c++) begin
      e_pulse[c] = 1'b0; e_busy[c] = 1'b0; e_miss[c] = 1'b0; e_armed[c] = 1'b1;
    end
    for (int j = 0; j < len; j++) begin
      bit cur, prv;
      cur = (j - SS + 1 >= 0) ? pat[j - SS + 1] : pre;
      prv = (j - SS >= 0) ? pat[j - SS] : pre;
      if (cur && !prv) begin
        if (j >= ready) begin
          last_busy = j + d + weff;
          for (int c = j + 1; c < len; c++) begin
            if (c <= last_busy) begin
              e_busy[c] = 1'b1; e_armed[c] = 1'b0; e_pulse[c] = (c > j + d);
            end else if (!cont) begin
              e_armed[c] = 1'b0;
            end
          end
          ready = cont ? last_busy + 1 : 32'h3fff_ffff;
        end else if (j <= last_busy && j + 1 < len) begin
          e_miss[j + 1] = 1'b1;
        end
      end
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({start_pulse, armed, busy, missed_trig} !== 4'b0) begin
      errors++; $display("FAIL reset_hold outputs got %b exp 0000", {start_pulse, armed, busy, missed_trig});
    end
    reset = 1'b0;
    repeat (2) step();
    checks++;
    if ({start_pulse, armed, busy, missed_trig} !== 4'b0) begin
      errors++; $display("FAIL reset_release outputs got %b exp 0000", {start_pulse, armed, busy, missed_trig});
    end
    // Reset config is D=0, W=1: arm without loading.
    arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 6; i++) pat[i] = 1'b1;
    drive_trace(6);
    model_trace(6, 0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({o_pulse[i], o_busy[i], o_miss[i], o_armed[i]} !== {e_pulse[i], e_busy[i], e_miss[i], e_armed[i]}) begin
        errors++; $display("FAIL reset_defaults cyc %0d pulse/busy/miss/armed got %b%b%b%b exp %b%b%b%b", i,
          o_pulse[i], o_busy[i], o_miss[i], o_armed[i], e_pulse[i], e_busy[i], e_miss[i], e_armed[i]);
      end
    end
  endtask

  task automatic test_basic();
    int first, cnt;
    prep(5, 3, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) pat[i] = 1'b1;
    drive_trace(14);
    model_trace(14, 5, 3, 1'b0, 1'b0);
    first = -1; cnt = 0;
    for (int i = 0; i < 14; i++) begin
      checks++;
      if ({o_pulse[i], o_busy[i], o_miss[i], o_armed[i]} !== {e_pulse[i], e_busy[i], e_miss[i], e_armed[i]}) begin
        errors++; $display("FAIL basic cyc %0d pulse/busy/miss/armed got %b%b%b%b exp %b%b%b%b", i,
          o_pulse[i], o_busy[i], o_miss[i], o_armed[i], e_pulse[i], e_busy[i], e_miss[i], e_armed[i]);
      end
      if (o_pulse[i] === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (first !== 7 || cnt !== 3) begin
      errors++; $display("FAIL basic_window first %0d width %0d exp first 7 width 3", first, cnt);
    end
  endtask

  task automatic test_min();
    int nb;
    prep(0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) pat[i] = 1'b1;
    drive_trace(8);
    model_trace(8, 0, 0, 1'b0, 1'b0);
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({o_pulse[i], o_busy[i], o_miss[i], o_armed[i]} !== {e_pulse[i], e_busy[i], e_miss[i], e_armed[i]}) begin
        errors++; $display("FAIL min cyc %0d pulse/busy/miss/armed got %b%b%b%b exp %b%b%b%b", i,
          o_pulse[i], o_busy[i], o_miss[i], o_armed[i], e_pulse[i], e_busy[i], e_miss[i], e_armed[i]);
      end
      if (o_busy[i] === 1'b1) nb++;
    end
    checks++;
    if (nb !== 1) begin
      errors++; $display("FAIL min_busy_cycles got %0d exp 1", nb);
    end
  endtask

  task automatic test_missed();
    int nm, np;
    prep(4, 2, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) pat[i] = (i == 0 || i == 3 || i == 23);
    drive_trace(40);
    model_trace(40, 4, 2, 1'b1, 1'b0);
    nm = 0; np = 0;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if ({o_pulse[i], o_busy[i], o_miss[i], o_armed[i]} !== {e_pulse[i], e_busy[i], e_miss[i], e_armed[i]}) begin
        errors++; $display("FAIL missed cyc %0d pulse/busy/miss/armed got %b%b%b%b exp %b%b%b%b", i,
          o_pulse[i], o_busy[i], o_miss[i], o_armed[i], e_pulse[i], e_busy[i], e_miss[i], e_armed[i]);
      end
      if (o_miss[i] === 1'b1) nm++;
      if (o_pulse[i] === 1'b1) np++;
    end
    checks++;
    if (nm !== 1 || np !== 4) begin
      errors++; $display("FAIL missed_counts miss %0d pulse %0d exp miss 1 pulse 4", nm, np);
    end
  endtask

  task automatic test_abort();
    bit seen;
    prep(100, 10, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      trig_in      = 1'b1;
      cfg_load     = (i == 20);
      coarse_delay = (i == 20) ? CNT_W'(1) : CNT_W'(100);
      abort        = (i == 52);
      step();
      if (start_pulse === 1'b1) seen = 1'b1;
      if (i == 30) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL abort_in_delay busy got %b exp 1", busy);
        end
      end
    end
    cfg_load = 1'b0; abort = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_pulse saw start_pulse got %b exp 0", seen);
    end
    checks++;
    if ({armed, busy, start_pulse} !== 3'b000) begin
      errors++; $display("FAIL abort_idle armed/busy/pulse got %b exp 000", {armed, busy, start_pulse});
    end
    // Next shot without reload must still use D=100.
    trig_in = 1'b0;
    coarse_delay = CNT_W'(1);
    repeat (4) step();
    arm = 1'b1; step(); arm = 1'b0;
    for (int i = 0; i < 120; i++) pat[i] = (i >= 2);
    drive_trace(120);
    model_trace(120, 100, 10, 1'b0, 1'b0);
    for (int i = 0; i < 120; i++) begin
      checks++;
      if ({o_pulse[i], o_busy[i], o_miss[i], o_armed[i]} !== {e_pulse[i], e_busy[i], e_miss[i], e_armed[i]}) begin
        errors++; $display("FAIL abort_next cyc %0d pulse/busy/miss/armed got %b%b%b%b exp %b%b%b%b", i,
          o_pulse[i], o_busy[i], o_miss[i], o_armed[i], e_pulse[i], e_busy[i], e_miss[i], e_armed[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int d, w, i;
      bit v;
      d = $urandom_range(0, 6);
      w = $urandom_range(0, 4);
      prep(d, w, 1'b1, 1'b0);
      i = 0; v = 1'b0;
      while (i < N) begin
        int h;
        h = $urandom_range(1, 8);
        for (int k = 0; k < h && i < N; k++) begin
          pat[i] = v; i++;
        end
        v = !v;
      end
      drive_trace(N);
      model_trace(N, d, w, 1'b1, 1'b0);
      for (int c = 0; c < N; c++) begin
        checks++;
        if ({o_pulse[c], o_busy[c], o_miss[c], o_armed[c]} !== {e_pulse[c], e_busy[c], e_miss[c], e_armed[c]}) begin
          errors++; $display("FAIL random r%0d D%0d W%0d cyc %0d pulse/busy/miss/armed got %b%b%b%b exp %b%b%b%b",
            r, d, w, c, o_pulse[c], o_busy[c], o_miss[c], o_armed[c], e_pulse[c], e_busy[c], e_miss[c], e_armed[c]);
        end
      end
    end
  endtask

  task automatic test_held_high_reset();
    // trig_in already high through arm: only the later fresh rise fires.
    prep(2, 6, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) pat[i] = (i < 8) || (i > 10);
    drive_trace(17);
    model_trace(17, 2, 6, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      checks++;
      if ({o_pulse[i], o_busy[i], o_miss[i], o_armed[i]} !== {e_pulse[i], e_busy[i], e_miss[i], e_armed[i]}) begin
        errors++; $display("FAIL held_high cyc %0d pulse/busy/miss/armed got %b%b%b%b exp %b%b%b%b", i,
          o_pulse[i], o_busy[i], o_miss[i], o_armed[i], e_pulse[i], e_busy[i], e_miss[i], e_armed[i]);
      end
    end
    // Mid-pulse now; reset between clock edges.
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({start_pulse, armed, busy, missed_trig} !== 4'b0) begin
      errors++; $display("FAIL reset_async outputs got %b exp 0000", {start_pulse, armed, busy, missed_trig});
    end
    repeat (2) step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({start_pulse, armed, busy, missed_trig} !== 4'b0) begin
        errors++; $display("FAIL reset_after cyc %0d outputs got %b exp 0000", i, {start_pulse, armed, busy, missed_trig});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min();
    test_missed();
    test_abort();
    test_random();
    test_held_high_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
